// File: rtl/pwm_apb_regs_if.sv
// APB3 bus bundle between a master and the PWM register bank.
interface pwm_apb_regs_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/pwm_apb_regs.sv
// APB3 register bank feeding the PWM generator. Software stages PERIOD/DUTY, then a
// commit validates the pair and copies it atomically to the active outputs.
module pwm_apb_regs #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned MAX_PERIOD_US = 4294967
) (
  input  logic                  clk,
  input  logic                  rst,
  pwm_apb_regs_if.slave         io_apb,
  output logic [DATA_WIDTH-1:0] o_pwm_period,
  output logic [DATA_WIDTH-1:0] o_pwm_duty
);

  localparam logic [ADDR_WIDTH-1:0] AddrCtrl   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] AddrPeriod = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] AddrDuty   = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus = ADDR_WIDTH'(12);
  localparam logic [DATA_WIDTH-1:0] MaxPeriod  = DATA_WIDTH'(MAX_PERIOD_US);

  // ApbWait covers the first access cycle, ApbDone is the single pready=1 cycle.
  typedef enum logic [1:0] {ApbIdle, ApbWait, ApbDone} apb_state_e;
  typedef enum logic [1:0] {CmtIdle, CmtCheck, CmtApply} cmt_state_e;

  apb_state_e            r_apb_state, w_apb_state_d;
  cmt_state_e            r_cmt_state, w_cmt_state_d;

  logic                  r_en;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_stg_period;
  logic [DATA_WIDTH-1:0] r_stg_duty;
  logic [DATA_WIDTH-1:0] r_act_period;
  logic [DATA_WIDTH-1:0] r_act_duty;
  logic [DATA_WIDTH-1:0] r_pwm_duty;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pslverr;

  logic                  w_busy;
  logic                  w_unaligned;
  logic                  w_sel_ctrl, w_sel_period, w_sel_duty, w_sel_status;
  logic                  w_capture;
  logic                  w_slverr;
  logic                  w_wr_en;
  logic                  w_commit_req;
  logic                  w_legal;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_busy       = (r_cmt_state != CmtIdle);
  assign w_unaligned  = (io_apb.paddr[1:0] != 2'b00);
  assign w_sel_ctrl   = (io_apb.paddr == AddrCtrl);
  assign w_sel_period = (io_apb.paddr == AddrPeriod);
  assign w_sel_duty   = (io_apb.paddr == AddrDuty);
  assign w_sel_status = (io_apb.paddr == AddrStatus);

  // Response is decided at the end of the wait cycle; the write itself lands at the end of
  // the pready cycle, gated by the already-registered error so both always agree.
  assign w_capture    = (r_apb_state == ApbWait) && io_apb.psel && io_apb.penable;
  assign w_slverr     = w_unaligned
                      || (io_apb.pwrite && w_sel_status)
                      || (io_apb.pwrite && w_busy && (w_sel_ctrl || w_sel_period || w_sel_duty));
  assign w_wr_en      = (r_apb_state == ApbDone) && io_apb.psel && io_apb.penable
                      && io_apb.pwrite && !r_pslverr;
  assign w_commit_req = w_wr_en && w_sel_ctrl && io_apb.pwdata[1];
  assign w_legal      = (r_stg_period != '0) && (r_stg_period <= MaxPeriod)
                      && (r_stg_duty <= r_stg_period);

  assign io_apb.pready  = (r_apb_state == ApbDone);
  assign io_apb.prdata  = r_prdata;
  assign io_apb.pslverr = r_pslverr;
  assign o_pwm_period   = r_act_period;
  assign o_pwm_duty     = r_pwm_duty;

  // Read data mux; unmapped bits and addresses read as 0.
  always_comb begin
    w_rdata = '0;
    if (!w_unaligned) begin
      if (w_sel_ctrl) begin
        w_rdata[0] = r_en;
      end else if (w_sel_period) begin
        w_rdata = r_stg_period;
      end else if (w_sel_duty) begin
        w_rdata = r_stg_duty;
      end else if (w_sel_status) begin
        w_rdata[0] = w_busy;
        w_rdata[1] = r_err;
      end
    end
  end

  // APB transfer FSM next state.
  always_comb begin
    w_apb_state_d = r_apb_state;
    case (r_apb_state)
      ApbIdle: if (io_apb.psel && !io_apb.penable) w_apb_state_d = ApbWait;
      ApbWait: begin
        if (!io_apb.psel) begin
          w_apb_state_d = ApbIdle;
        end else if (io_apb.penable) begin
          w_apb_state_d = ApbDone;
        end
      end
      ApbDone: w_apb_state_d = ApbIdle;
      default: w_apb_state_d = ApbIdle;
    endcase
  end

  // APB transfer FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_apb_state <= ApbIdle;
    else      r_apb_state <= w_apb_state_d;
  end

  // Response registers: valid only during the pready cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      r_prdata  <= (w_capture && !io_apb.pwrite) ? w_rdata : '0;
      r_pslverr <= w_capture && w_slverr;
    end
  end

  // Software-writable registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en         <= 1'b0;
      r_stg_period <= '0;
      r_stg_duty   <= '0;
    end else if (w_wr_en) begin
      if (w_sel_ctrl)   r_en         <= io_apb.pwdata[0];
      if (w_sel_period) r_stg_period <= io_apb.pwdata;
      if (w_sel_duty)   r_stg_duty   <= io_apb.pwdata;
    end
  end

  // Commit FSM next state; staging is frozen while busy since writes are rejected.
  always_comb begin
    w_cmt_state_d = r_cmt_state;
    case (r_cmt_state)
      CmtIdle:  if (w_commit_req) w_cmt_state_d = CmtCheck;
      CmtCheck: w_cmt_state_d = w_legal ? CmtApply : CmtIdle;
      CmtApply: w_cmt_state_d = CmtIdle;
      default:  w_cmt_state_d = CmtIdle;
    endcase
  end

  // Commit FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cmt_state <= CmtIdle;
    else      r_cmt_state <= w_cmt_state_d;
  end

  // Active pair and sticky error, updated only by the commit FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act_period <= '0;
      r_act_duty   <= '0;
      r_err        <= 1'b0;
    end else if (r_cmt_state == CmtCheck && !w_legal) begin
      r_err <= 1'b1;
    end else if (r_cmt_state == CmtApply) begin
      r_act_period <= r_stg_period;
      r_act_duty   <= r_stg_duty;
      r_err        <= 1'b0;
    end
  end

  // Gated duty output: zero holds the PWM low while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pwm_duty <= '0;
    else      r_pwm_duty <= r_en ? r_act_duty : '0;
  end

endmodule

// File: tb/tb_pwm_apb_regs.sv
// Directed bench for pwm_apb_regs: table of register accesses plus commit/EN/reset sequences.
module tb_pwm_apb_regs;

  logic clk;
  logic rst;
  logic [31:0] pwm_period;
  logic [31:0] pwm_duty;
  int total;
  int bad;

  pwm_apb_regs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) apb ();

  pwm_apb_regs #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(4),
    .MAX_PERIOD_US(4294967)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io_apb      (apb),
    .o_pwm_period(pwm_period),
    .o_pwm_duty  (pwm_duty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full APB transfer; called and returns at a negative clock edge.
  task automatic access(input string name, input bit wr, input logic [3:0] addr,
                        input logic [31:0] data, input bit chk_rd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int   waits;
    logic seen;
    logic [31:0] rd;
    logic err;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = data;
    @(negedge clk);
    apb.penable = 1'b1;
    waits = 0;
    seen  = 1'b0;
    if (apb.pready) seen = 1'b1;
    else waits++;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (apb.pready) seen = 1'b1;
      else waits++;
    end
    rd  = apb.prdata;
    err = apb.pslverr;
    @(negedge clk);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    chk({name, "_ready"}, 32'(seen), 32'd1);
    chk({name, "_waits"}, waits, 32'd1);
    chk({name, "_ready_drop"}, 32'(apb.pready), 32'd0);
    chk({name, "_slverr"}, 32'(err), 32'(exp_err));
    if (chk_rd) chk({name, "_rdata"}, rd, exp_rd);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0;  apb.pwdata = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk("rst_pready", 32'(apb.pready), 32'd0);
    chk("rst_pslverr", 32'(apb.pslverr), 32'd0);
    chk("rst_prdata", apb.prdata, 32'd0);
    chk("rst_period", pwm_period, 32'd0);
    chk("rst_duty", pwm_duty, 32'd0);

    vecs.push_back('{"rd_status0", 1'b0, 4'hC, 32'h0,   1'b1, 32'h0,  1'b0});
    vecs.push_back('{"wr_period",  1'b1, 4'h4, 32'd100, 1'b0, 32'h0,  1'b0});
    vecs.push_back('{"rd_period",  1'b0, 4'h4, 32'h0,   1'b1, 32'd100, 1'b0});
    vecs.push_back('{"wr_duty",    1'b1, 4'h8, 32'd25,  1'b0, 32'h0,  1'b0});
    vecs.push_back('{"rd_duty",    1'b0, 4'h8, 32'h0,   1'b1, 32'd25, 1'b0});
    vecs.push_back('{"rd_ctrl",    1'b0, 4'h0, 32'h0,   1'b1, 32'h0,  1'b0});
    vecs.push_back('{"wr_unalign", 1'b1, 4'h2, 32'd55,  1'b0, 32'h0,  1'b1});
    vecs.push_back('{"wr_status",  1'b1, 4'hC, 32'h3,   1'b0, 32'h0,  1'b1});
    vecs.push_back('{"rd_status1", 1'b0, 4'hC, 32'h0,   1'b1, 32'h0,  1'b0});
    vecs.push_back('{"rd_period2", 1'b0, 4'h4, 32'h0,   1'b1, 32'd100, 1'b0});
    vecs.push_back('{"rd_duty2",   1'b0, 4'h8, 32'h0,   1'b1, 32'd25, 1'b0});
    foreach (vecs[i])
      access(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].data,
             vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_err);

    // EN + COMMIT together: period lands two edges after the write, duty one later.
    access("commit1", 1'b1, 4'h0, 32'h3, 1'b0, 32'h0, 1'b0);
    chk("commit1_hold_period", pwm_period, 32'd0);
    repeat (2) @(negedge clk);
    chk("commit1_period", pwm_period, 32'd100);
    chk("commit1_duty_early", pwm_duty, 32'd0);
    @(negedge clk);
    chk("commit1_duty", pwm_duty, 32'd25);
    access("commit1_status", 1'b0, 4'hC, 32'h0, 1'b1, 32'h0, 1'b0);
    access("rd_ctrl_en", 1'b0, 4'h0, 32'h0, 1'b1, 32'h1, 1'b0);

    // Duty above period is rejected; outputs hold.
    access("wr_duty150", 1'b1, 4'h8, 32'd150, 1'b0, 32'h0, 1'b0);
    access("commit_bad_duty", 1'b1, 4'h0, 32'h3, 1'b0, 32'h0, 1'b0);
    settle();
    access("status_err_duty", 1'b0, 4'hC, 32'h0, 1'b1, 32'h2, 1'b0);
    chk("bad_duty_period", pwm_period, 32'd100);
    chk("bad_duty_duty", pwm_duty, 32'd25);
    access("wr_duty50", 1'b1, 4'h8, 32'd50, 1'b0, 32'h0, 1'b0);
    access("commit_duty50", 1'b1, 4'h0, 32'h3, 1'b0, 32'h0, 1'b0);
    settle();
    access("status_clr", 1'b0, 4'hC, 32'h0, 1'b1, 32'h0, 1'b0);
    chk("duty50", pwm_duty, 32'd50);

    // Period bounds: one above max, exactly max, zero.
    access("wr_period_big", 1'b1, 4'h4, 32'd4294968, 1'b0, 32'h0, 1'b0);
    access("commit_big", 1'b1, 4'h0, 32'h3, 1'b0, 32'h0, 1'b0);
    settle();
    access("status_err_big", 1'b0, 4'hC, 32'h0, 1'b1, 32'h2, 1'b0);
    chk("big_period_hold", pwm_period, 32'd100);
    access("wr_period_max", 1'b1, 4'h4, 32'd4294967, 1'b0, 32'h0, 1'b0);
    access("commit_max", 1'b1, 4'h0, 32'h3, 1'b0, 32'h0, 1'b0);
    settle();
    access("status_max", 1'b0, 4'hC, 32'h0, 1'b1, 32'h0, 1'b0);
    chk("max_period", pwm_period, 32'd4294967);
    access("wr_period_zero", 1'b1, 4'h4, 32'd0, 1'b0, 32'h0, 1'b0);
    access("commit_zero", 1'b1, 4'h0, 32'h3, 1'b0, 32'h0, 1'b0);
    settle();
    access("status_err_zero", 1'b0, 4'hC, 32'h0, 1'b1, 32'h2, 1'b0);
    chk("zero_period_hold", pwm_period, 32'd4294967);

    // Back-to-back write right after a commit hits BUSY.
    access("wr_period100", 1'b1, 4'h4, 32'd100, 1'b0, 32'h0, 1'b0);
    access("wr_duty25", 1'b1, 4'h8, 32'd25, 1'b0, 32'h0, 1'b0);
    access("commit_busy", 1'b1, 4'h0, 32'h3, 1'b0, 32'h0, 1'b0);
    access("wr_period_busy", 1'b1, 4'h4, 32'd777, 1'b0, 32'h0, 1'b1);
    settle();
    access("rd_period_busy", 1'b0, 4'h4, 32'h0, 1'b1, 32'd100, 1'b0);
    chk("busy_period", pwm_period, 32'd100);
    chk("busy_duty", pwm_duty, 32'd25);

    // Enable gating: duty drops one edge after the EN write, period untouched.
    access("en_off", 1'b1, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("en_off_duty", pwm_duty, 32'd0);
    chk("en_off_period", pwm_period, 32'd100);
    access("en_on", 1'b1, 4'h0, 32'h1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("en_on_duty", pwm_duty, 32'd25);

    // Async reset while pready is high.
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 4'h4;
    @(negedge clk);
    apb.penable = 1'b1;
    @(negedge clk);
    chk("mid_pready_before", 32'(apb.pready), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_pready", 32'(apb.pready), 32'd0);
    chk("mid_rst_period", pwm_period, 32'd0);
    chk("mid_rst_duty", pwm_duty, 32'd0);
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    access("post_rst_status", 1'b0, 4'hC, 32'h0, 1'b1, 32'h0, 1'b0);
    access("post_rst_period", 1'b0, 4'h4, 32'h0, 1'b1, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
